des_key_sched_ctrl: RTL
=======================

Name: des_key_sched_ctrl

Overview:
- Iterative DES key-schedule sequencer. It replaces the fully unrolled 16-stage key expansion with a single 56-bit C/D register and one KeyExpansionPermChoice2 instance.
- It emits one 48-bit round key per accepted handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- It sits between key load and the iterative DES round engine.

Parameters:
- SHIFT_MAP, 16'h8103: bit r-1 set means round r uses a 1-bit rotate, clear means a 2-bit rotate. The default gives 1-bit rotates for rounds 1, 2, 9 and 16.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  request a new key schedule; sampled only in IDLE
- decrypt  in  1  direction, sampled with start: 0 = K1 first, 1 = K16 first
- inputKey  in  56  C0||D0 (post PC-1); C0 = [55:28], D0 = [27:0]; sampled with start
- roundKeyReady  in  1  consumer accepts the current key
- roundKey  out  48  PC-2 of the C/D register (combinational from register)
- roundKeyValid  out  1  roundKey/roundNum are valid
- roundNum  out  4  DES round of the current key minus 1 (0 = K1, 15 = K16)
- busy  out  1  high in EMIT
- done  out  1  one-cycle pulse after the last key is accepted

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE, C/D reg = 0, roundNum = 0, roundKeyValid = 0, busy = 0, done = 0. roundKey = PC2(0) = 0.
- States: IDLE and EMIT.
- IDLE, start = 1 (accept):
  - Latch the direction.
  - Encrypt: CD <= rotl1(inputKey), roundNum <= 0.
  - Decrypt: CD <= inputKey (rotation sum is 28, so CD16 = CD0), roundNum <= 15.
  - Next state EMIT.
  - inputKey/decrypt are don't-care when start = 0.
- rotl by n: each 28-bit half rotates independently, MSB wraps to LSB: C <= {C[27-n:0], C[27:28-n]}. D likewise. rotr is the inverse.
- EMIT:
  - roundKeyValid = 1, busy = 1.
  - roundKey, roundNum and CD are held stable while roundKeyReady = 0, indefinitely.
- EMIT, handshake (valid & ready), not last:
  - Encrypt: roundNum += 1; CD <= rotl(CD, SHIFT_MAP[roundNum+1] ? 1 : 2).
  - Decrypt: CD <= rotr(CD, SHIFT_MAP[roundNum] ? 1 : 2); roundNum -= 1.
  - The next key is valid the following cycle with no bubble.
- EMIT, handshake on the last key (encrypt roundNum = 15, decrypt roundNum = 0):
  - Next state IDLE; done = 1 for exactly one cycle; roundKeyValid = 0 that cycle.
  - CD and roundNum hold their last values.
- Latency:
  - Start accepted at cycle t gives the first valid key at t+1.
  - With ready tied high, keys appear at t+1..t+16 and done pulses at t+17.
- start while busy: ignored, with no effect on sequence or outputs.
- start in the cycle done is high: accepted (state is IDLE), so a new schedule begins back-to-back.
- rst mid-sequence: next cycle all outputs take their reset values and any partial schedule is discarded. rst has priority over start and over the handshake.
- roundNum never wraps: increment and decrement stop at the terminal round.

Test Plan:
1. Encrypt, ready = 1: rst, then start with decrypt = 0, inputKey = 56'hF0CCAAF556678F.
   - Cycle +1: roundKey = 48'h1B02EFFC7072, roundNum = 0.
   - Cycle +16: roundKey = 48'hCB3D8B0E17F5, roundNum = 15.
   - done at +17; all 16 keys match the golden DES key-schedule model.
2. Decrypt: same key, decrypt = 1.
   - First key = 48'hCB3D8B0E17F5 with roundNum = 15.
   - Last key = 48'h1B02EFFC7072 with roundNum = 0.
   - The sequence equals test 1 reversed.
3. Backpressure: test 1 with roundKeyReady randomly low about 50% of cycles.
   - roundKey/roundNum stay stable while ready = 0.
   - Exactly 16 handshakes, the same key sequence, and one done pulse.
4. start pulses during EMIT (key 56'h0123456789ABCD) -> the running sequence is unaffected. start asserted on the done cycle -> a new sequence begins, first valid key on the next cycle.
5. rst asserted at roundNum = 7 mid-encrypt.
   - Next cycle: roundKeyValid = 0, busy = 0, roundNum = 0, done never pulses.
   - A following start replays from K1 = 48'h1B02EFFC7072.
6. Key 56'h0 and 56'hFFFFFFFFFFFFFF in both directions -> all 16 roundKeys are 0 and 48'hFFFFFFFFFFFF respectively, with 16-key timing as in test 1.

Source files
------------

// File: rtl/des_key_sched_ctrl_if.sv
// Handshake bundle between key loader / round engine and the DES key-schedule sequencer.
interface des_key_sched_ctrl_if;
  logic        start;
  logic        decrypt;
  logic [55:0] inputKey;
  logic        roundKeyReady;
  logic [47:0] roundKey;
  logic        roundKeyValid;
  logic [3:0]  roundNum;
  logic        busy;
  logic        done;

  modport master (
    output start, decrypt, inputKey, roundKeyReady,
    input  roundKey, roundKeyValid, roundNum, busy, done
  );

  modport slave (
    input  start, decrypt, inputKey, roundKeyReady,
    output roundKey, roundKeyValid, roundNum, busy, done
  );
endinterface

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key schedule: one 56-bit C/D register rotated per round, PC-2 applied
// combinationally, one round key per valid/ready handshake in encrypt or decrypt order.
module des_key_sched_ctrl #(
  parameter logic [15:0] SHIFT_MAP = 16'h8103
) (
  input  logic                  clk,
  input  logic                  rst,
  des_key_sched_ctrl_if.slave   bus
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic        last_key;
  logic [3:0]  round_inc;

  // Rotate C and D independently; left moves toward encrypt order, right undoes it.
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left,
                                         input logic one);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (left) begin
      if (one) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end else begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end
    end else begin
      if (one) begin
        c = {c[0], c[27:1]};
        d = {d[0], d[27:1]};
      end else begin
        c = {c[1:0], c[27:2]};
        d = {d[1:0], d[27:2]};
      end
    end
    return {c, d};
  endfunction

  // PC-2: each index is 56 minus the standard table entry (entry 1 is the C/D MSB).
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    return {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
            cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
            cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
            cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
            cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
            cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
            cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
            cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
  endfunction

  assign round_inc = round_q + 4'd1;
  assign last_key  = dec_q ? (round_q == 4'd0) : (round_q == 4'd15);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = EMIT;
          dec_d   = bus.decrypt;
          if (bus.decrypt) begin
            // Total rotation over 16 rounds is 28, so CD16 equals CD0.
            cd_d    = bus.inputKey;
            round_d = 4'd15;
          end else begin
            cd_d    = rot_cd(bus.inputKey, 1'b1, 1'b1);
            round_d = 4'd0;
          end
        end
      end
      EMIT: begin
        if (bus.roundKeyReady) begin
          if (last_key) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (!dec_q) begin
            round_d = round_inc;
            cd_d    = rot_cd(cd_q, 1'b1, SHIFT_MAP[round_inc]);
          end else begin
            round_d = round_q - 4'd1;
            cd_d    = rot_cd(cd_q, 1'b0, SHIFT_MAP[round_q]);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign bus.roundKey      = pc2(cd_q);
  assign bus.roundKeyValid = (state_q == EMIT);
  assign bus.busy          = (state_q == EMIT);
  assign bus.roundNum      = round_q;
  assign bus.done          = done_q;

endmodule
